// File: rtl/reg_file_pkg.sv
// Shared CPU datapath package.
// Holds the register-file geometry, the hardwired zero index and the
// register-index / data-word types that the destination select, the
// register file and the pipeline registers all agree on.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus.
// Bundles the write port, the two operand read ports and the debug
// observation port.
//   master : drives wrEn/wrAddr/wrData, rdAddrA/rdAddrB, dbgAddr;
//            receives rdDataA/rdDataB/dbgData
//   slave  : the register file itself (mirror of master)
interface reg_file_if;
    import reg_file_pkg::*;

    logic     wrEn;
    reg_idx_t wrAddr;
    word_t    wrData;
    reg_idx_t rdAddrA;
    word_t    rdDataA;
    reg_idx_t rdAddrB;
    word_t    rdDataB;
    reg_idx_t dbgAddr;
    word_t    dbgData;

    modport master (
        output wrEn, wrAddr, wrData,
        output rdAddrA, rdAddrB, dbgAddr,
        input  rdDataA, rdDataB, dbgData
    );

    modport slave (
        input  wrEn, wrAddr, wrData,
        input  rdAddrA, rdAddrB, dbgAddr,
        output rdDataA, rdDataB, dbgData
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file.
// Ports:
//   rst_n    in  reset (active-low); forces the output to zero
//   regs     in  array contents, entries 1..2^ADDR_W-1
//   rd_addr  in  read address
//   wr_en    in  write enable of the write port (for bypass)
//   wr_addr  in  write address (for bypass)
//   wr_data  in  write data (bypass source)
//   rd_data  out read data
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic                                   rst_n,
    input  logic [(1<<ADDR_W)-1:1][DATA_W-1:0]     regs,
    input  logic [ADDR_W-1:0]                      rd_addr,
    input  logic                                   wr_en,
    input  logic [ADDR_W-1:0]                      wr_addr,
    input  logic [DATA_W-1:0]                      wr_data,
    output logic [DATA_W-1:0]                      rd_data
);

    // Priority: reset, then the hardwired zero register, then the
    // same-cycle bypass of the value being written back, then the array.
    // Reset must also suppress the bypass so outputs read zero in reset.
    always_comb begin
        rd_data = '0;
        if (!rst_n) begin
            rd_data = '0;
        end else if (rd_addr == ADDR_W'(REG_ZERO)) begin
            rd_data = '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end else begin
            rd_data = regs[rd_addr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file with register 0 hardwired to zero,
// two bypassed combinational read ports and a raw debug read port.
// Ports:
//   clk    in  clock, all writes on the rising edge
//   rst_n  in  asynchronous active-low reset, clears every register
//   bus    slave modport of reg_file_if:
//            wrEn/wrAddr/wrData   write port
//            rdAddrA -> rdDataA   operand read port A (rs), bypassed
//            rdAddrB -> rdDataB   operand read port B (rt), bypassed
//            dbgAddr -> dbgData   debug read, array contents only
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_file_if.slave   bus
);

    // Index 0 has no storage; the array starts at 1.
    logic [(1<<ADDR_W)-1:1][DATA_W-1:0] regs;

    // Writes to the zero register are dropped rather than stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (bus.wrEn && (bus.wrAddr != REG_ZERO)) begin
            regs[bus.wrAddr] <= bus.wrData;
        end
    end

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .rst_n   (rst_n),
        .regs    (regs),
        .rd_addr (bus.rdAddrA),
        .wr_en   (bus.wrEn),
        .wr_addr (bus.wrAddr),
        .wr_data (bus.wrData),
        .rd_data (bus.rdDataA)
    );

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .rst_n   (rst_n),
        .regs    (regs),
        .rd_addr (bus.rdAddrB),
        .wr_en   (bus.wrEn),
        .wr_addr (bus.wrAddr),
        .wr_data (bus.wrData),
        .rd_data (bus.rdDataB)
    );

    // Debug port shows the stored contents only, so it lags a write by
    // one edge even when the read ports are bypassing.
    always_comb begin
        bus.dbgData = '0;
        if (bus.dbgAddr != REG_ZERO) begin
            bus.dbgData = regs[bus.dbgAddr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: reset, basic write/read, zero register,
// same-cycle bypass, write disable and reset during a write.
module tb_reg_file;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    reg_file_if bus ();

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; one write occupies one cycle.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.wrEn   = 1'b1;
        bus.wrAddr = addr;
        bus.wrData = data;
        @(posedge clk);
        #1;
        bus.wrEn   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.wrEn    = 1'b0;
        bus.wrAddr  = 5'd0;
        bus.wrData  = '0;
        bus.rdAddrA = 5'd5;
        bus.rdAddrB = 5'd31;
        bus.dbgAddr = 5'd5;
        #3;
        tests_run++;
        if (bus.rdDataA !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdA: got %h expected %h", bus.rdDataA, 32'h0);
        end
        tests_run++;
        if (bus.rdDataB !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdB: got %h expected %h", bus.rdDataB, 32'h0);
        end
        tests_run++;
        if (bus.dbgData !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dbg: got %h expected %h", bus.dbgData, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_write(5'd5, 32'hDEADBEEF);
        tests_run++;
        if (bus.dbgData !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL reset_pre_r5: got %h expected %h", bus.dbgData, 32'hDEADBEEF);
        end
        // Pulse reset between edges; clearing must not wait for the clock.
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.dbgData !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async_dbg: got %h expected %h", bus.dbgData, 32'h0);
        end
        bus.wrEn    = 1'b1;
        bus.wrAddr  = 5'd5;
        bus.wrData  = 32'h0BAD0BAD;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_bypass: got %h expected %h", bus.rdDataA, 32'h0);
        end
        bus.wrEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_after_rdA: got %h expected %h", bus.rdDataA, 32'h0);
        end
    endtask

    task automatic test_basic();
        do_write(5'd7, 32'h12345678);
        // While r31 is written, port A reads r7: different address, no bypass.
        @(negedge clk);
        bus.wrEn    = 1'b1;
        bus.wrAddr  = 5'd31;
        bus.wrData  = 32'hFFFFFFFF;
        bus.rdAddrA = 5'd7;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL basic_no_bypass: got %h expected %h", bus.rdDataA, 32'h12345678);
        end
        @(posedge clk);
        #1;
        bus.wrEn = 1'b0;
        @(negedge clk);
        bus.rdAddrA = 5'd7;
        bus.rdAddrB = 5'd31;
        bus.dbgAddr = 5'd31;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL basic_rdA: got %h expected %h", bus.rdDataA, 32'h12345678);
        end
        tests_run++;
        if (bus.rdDataB !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("[TB] FAIL basic_rdB: got %h expected %h", bus.rdDataB, 32'hFFFFFFFF);
        end
        tests_run++;
        if (bus.dbgData !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("[TB] FAIL basic_dbg: got %h expected %h", bus.dbgData, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        bus.wrEn    = 1'b1;
        bus.wrAddr  = 5'd0;
        bus.wrData  = 32'hA5A5A5A5;
        bus.rdAddrA = 5'd0;
        bus.rdAddrB = 5'd0;
        bus.dbgAddr = 5'd0;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL zero_same_rdA: got %h expected %h", bus.rdDataA, 32'h0);
        end
        tests_run++;
        if (bus.rdDataB !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL zero_same_rdB: got %h expected %h", bus.rdDataB, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.wrEn = 1'b0;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL zero_after_rdA: got %h expected %h", bus.rdDataA, 32'h0);
        end
        tests_run++;
        if (bus.dbgData !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL zero_after_dbg: got %h expected %h", bus.dbgData, 32'h0);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd3, 32'h1);
        @(negedge clk);
        bus.wrEn    = 1'b1;
        bus.wrAddr  = 5'd3;
        bus.wrData  = 32'h2;
        bus.rdAddrA = 5'd3;
        bus.rdAddrB = 5'd3;
        bus.dbgAddr = 5'd3;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL bypass_rdA: got %h expected %h", bus.rdDataA, 32'h2);
        end
        tests_run++;
        if (bus.rdDataB !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL bypass_rdB: got %h expected %h", bus.rdDataB, 32'h2);
        end
        tests_run++;
        if (bus.dbgData !== 32'h1) begin
            tests_failed++;
            $display("[TB] FAIL bypass_dbg_old: got %h expected %h", bus.dbgData, 32'h1);
        end
        @(posedge clk);
        #1;
        bus.wrEn = 1'b0;
        #1;
        tests_run++;
        if (bus.dbgData !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL bypass_dbg_new: got %h expected %h", bus.dbgData, 32'h2);
        end
        tests_run++;
        if (bus.rdDataB !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL bypass_rdB_stored: got %h expected %h", bus.rdDataB, 32'h2);
        end
    endtask

    task automatic test_write_disable();
        do_write(5'd9, 32'h00000099);
        @(negedge clk);
        bus.wrEn    = 1'b0;
        bus.wrAddr  = 5'd9;
        bus.wrData  = 32'hCAFE0000;
        bus.rdAddrA = 5'd9;
        bus.dbgAddr = 5'd9;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h00000099) begin
            tests_failed++;
            $display("[TB] FAIL wrdis_no_bypass: got %h expected %h", bus.rdDataA, 32'h00000099);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.dbgData !== 32'h00000099) begin
            tests_failed++;
            $display("[TB] FAIL wrdis_dbg: got %h expected %h", bus.dbgData, 32'h00000099);
        end
        tests_run++;
        if (bus.rdDataA !== 32'h00000099) begin
            tests_failed++;
            $display("[TB] FAIL wrdis_rdA: got %h expected %h", bus.rdDataA, 32'h00000099);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        bus.wrEn    = 1'b1;
        bus.wrAddr  = 5'd12;
        bus.wrData  = 32'h55;
        bus.rdAddrA = 5'd12;
        bus.dbgAddr = 5'd12;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bus.wrEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.rdDataA !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rstwr_rdA: got %h expected %h", bus.rdDataA, 32'h0);
        end
        tests_run++;
        if (bus.dbgData !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rstwr_dbg: got %h expected %h", bus.dbgData, 32'h0);
        end
        bus.dbgAddr = 5'd7;
        #1;
        tests_run++;
        if (bus.dbgData !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rstwr_r7_cleared: got %h expected %h", bus.dbgData, 32'h0);
        end
        do_write(5'd12, 32'h77);
        bus.dbgAddr = 5'd12;
        #1;
        tests_run++;
        if (bus.dbgData !== 32'h77) begin
            tests_failed++;
            $display("[TB] FAIL rstwr_first_write: got %h expected %h", bus.dbgData, 32'h77);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_write_disable();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

32-entry × 32-bit general-purpose register file for the CPU datapath. It sits directly downstream of the 5-bit write-destination select (rt/rd choice). The select output drives this block's write address, and its two read ports feed the operand path. Register 0 is hardwired to zero. A same-cycle write-to-read bypass lets an instruction read a value being written back in the same cycle.

## Interface

Parameters:
- `DATA_W`, 32, register and data width.
- `ADDR_W`, 5, address width; the register count is 2^ADDR_W = 32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low. Assertion immediately clears all registers. Deassertion is synchronous to `clk` at the integration level.
- `wrEn`  in  1  write enable for the write port.
- `wrAddr`  in  5  write destination, driven by the 5-bit destination select.
- `wrData`  in  32  write-back data.
- `rdAddrA`  in  5  read port A address (rs).
- `rdDataA`  out  32  read port A data.
- `rdAddrB`  in  5  read port B address (rt).
- `rdDataB`  out  32  read port B data.
- `dbgAddr`  in  5  debug/observation read address.
- `dbgData`  out  32  debug read data; raw array contents, no bypass.

## Operation

- **Storage:** 31 writable 32-bit registers, indices 1..31. Index 0 has no storage and always reads 0.
- **Write:** on the rising edge of `clk` with `rst_n`=1, `wrEn`=1 and `wrAddr`≠0, register[`wrAddr`] ← `wrData`.
  - If `wrAddr`=0, the write is silently dropped.
  - If `wrEn`=0, no register changes.
- **Read ports A/B (combinational):**
  - If address=0, output 0.
  - Else if `wrEn`=1 and `wrAddr`=address, output `wrData` (bypass).
  - Else output register[address].
- Both read ports may address the same register; both then return the identical value, including the bypassed value.
- **Debug port:** combinational. Outputs register[`dbgAddr`], or 0 when `dbgAddr`=0. It never bypasses.
- **Reset:**
  - While `rst_n`=0, all registers are held at 0 and writes are ignored.
  - All outputs therefore reset to 0: `rdDataA`=`rdDataB`=0 regardless of bypass, and `dbgData`=0.
  - Reset asserted mid-operation discards any pending write in that cycle.
- **Widths:** all addresses are full 5-bit, so no out-of-range case exists. Data passes through unmodified, with no sign or zero extension.

## Timing

- **Write latency:** data presented in cycle N is visible through the array (debug port, non-bypassed reads) from cycle N+1.
- **Read latency:** 0 cycles (combinational from address or bypass inputs).
- **Bypass:** same-cycle. This covers the write-back/decode overlap without an extra forwarding stage.
- **Simultaneous write and read of the same index:** reads return the new `wrData`; `dbgData` returns the old contents until the edge.
- **Reset:** `rst_n` falling clears the array asynchronously, without waiting for `clk`. The first write is accepted on the first rising edge after `rst_n` is sampled high.
- **Critical path:** `wrAddr`/`rdAddr` compare plus 32:1 read mux plus bypass mux. There is no internal pipelining.

## Structure

- **Shared CPU package:**
  - `DATA_W` and `ADDR_W`.
  - `REG_ZERO`=5'd0.
  - `NUM_REGS`=32.
  - Register-index typedef (5-bit) and data-word typedef (32-bit), also used by the destination select and pipeline registers.
- **Sub-module:** `reg_file_read_port`, instantiated twice (A and B). It takes the array, read address, `wrEn`/`wrAddr`/`wrData` and `rst_n`, and performs the zero-check, bypass compare and output mux.
- The debug port is a plain array index inline in `reg_file`.

## Test plan

- **Reset:** write 32'hDEADBEEF to r5, then pulse `rst_n`=0 between clock edges → `dbgData`(r5)=0 immediately, and `rdDataA`(r5)=0 after release.
- **Basic write/read:** write r7=32'h12345678 then r31=32'hFFFFFFFF; next cycle set `rdAddrA`=7, `rdAddrB`=31 → outputs 32'h12345678 and 32'hFFFFFFFF.
- **Zero register:** `wrEn`=1, `wrAddr`=0, `wrData`=32'hA5A5A5A5 → `rdDataA`(0)=0 in the same cycle and after the edge; `dbgData`(0)=0.
- **Bypass:** r3 holds 32'h1; in one cycle write r3=32'h2 with `rdAddrA`=`rdAddrB`=`dbgAddr`=3 → `rdDataA`=`rdDataB`=32'h2 and `dbgData`=32'h1 before the edge; `dbgData`=32'h2 after it.
- **Write disable:** `wrEn`=0, `wrAddr`=9, `wrData`=32'hCAFE0000 → r9 unchanged and no bypass (`rdDataA`(9) shows the old value).
- **Reset mid-write:** `rst_n` asserted in the same cycle as a write of r12=32'h55 → r12=0 after release.
